// File: rtl/ts_packet_arbiter_if.sv
// Byte-stream handshake bundle between the four synchronized TS sources,
// the packet arbiter (master side) and the downstream output stage.
interface ts_packet_arbiter_if;
  logic [31:0] in_byte;
  logic [3:0]  in_valid;
  logic [3:0]  in_sync;
  logic [3:0]  in_ready;
  logic [7:0]  out_byte;
  logic        out_valid;
  logic        out_ready;
  logic        out_sop;
  logic [1:0]  out_chan;
  logic        abort;

  modport master (
    input  in_byte, in_valid, in_sync, out_ready,
    output in_ready, out_byte, out_valid, out_sop, out_chan, abort
  );

  modport slave (
    output in_byte, in_valid, in_sync, out_ready,
    input  in_ready, out_byte, out_valid, out_sop, out_chan, abort
  );
endinterface

// File: rtl/ts_packet_arbiter.sv
// Packet-level round-robin scheduler merging four TS byte streams into one.
// Optional null-packet insertion on long idle: define TS_ARB_NULL_INSERT_EN.
module ts_packet_arbiter #(
  parameter int PKT_LEN   = 188,
  parameter int TIMEOUT   = 1024,
  parameter int NULL_WAIT = 376
) (
  input  logic                clk,
  input  logic                rst,
  ts_packet_arbiter_if.master bus
);

  if (PKT_LEN < 4 || PKT_LEN > 255 || TIMEOUT < 1 || TIMEOUT > 65535 ||
      NULL_WAIT < 1 || NULL_WAIT > 65535) begin : g_param_check
    $error("ts_packet_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XFER = 2'd1,
    S_NULL = 2'd2
  } state_t;

  state_t      r_state;
  logic [1:0]  r_rr_last;
  logic [1:0]  r_grant;
  logic [7:0]  r_count;
  logic [15:0] r_timer;
  logic [7:0]  r_out_byte;
  logic        r_out_valid;
  logic        r_out_sop;
  logic [1:0]  r_out_chan;
  logic        r_abort;
`ifdef TS_ARB_NULL_INSERT_EN
  logic [15:0] r_idle_cnt;
`endif

  logic [3:0]  w_elig;
  logic        w_found;
  logic [1:0]  w_pick;
  logic [7:0]  w_gbyte;
  logic        w_load_ok;
  logic        w_sync_g;
  logic        w_xfer;
  logic        w_last;
  logic        w_timeout;

  // First eligible channel after 'last'; offset 4 (= last itself) ranks lowest.
  function automatic logic [2:0] rr_pick(input logic [3:0] elig, input logic [1:0] last);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int i = 4; i >= 1; i--) begin
      idx = last + 2'(i);
      if (elig[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

`ifdef TS_ARB_NULL_INSERT_EN
  function automatic logic [7:0] null_byte(input logic [7:0] idx);
    case (idx)
      8'd0:    return 8'h47;
      8'd1:    return 8'h1F;
      8'd2:    return 8'hFF;
      8'd3:    return 8'h10;
      default: return 8'hFF;
    endcase
  endfunction
`endif

  always_comb begin
    w_elig = '0;
    for (int c = 0; c < 4; c++)
      w_elig[c] = bus.in_sync[c] && bus.in_valid[c] && (bus.in_byte[8*c +: 8] == 8'h47);
  end

  assign {w_found, w_pick} = rr_pick(w_elig, r_rr_last);
  assign w_gbyte   = bus.in_byte[{r_grant, 3'b000} +: 8];
  assign w_load_ok = !r_out_valid || bus.out_ready;
  assign w_sync_g  = bus.in_sync[r_grant];
  // Sync loss gates the accept directly, so a completing byte is refused too.
  assign w_xfer    = (r_state == S_XFER) && w_sync_g && bus.in_valid[r_grant] && w_load_ok;
  assign w_last    = (r_count == 8'(PKT_LEN - 1));
  assign w_timeout = !w_xfer && (r_timer == 16'(TIMEOUT - 1));

  always_comb begin
    bus.in_ready = '0;
    if (r_state == S_XFER && w_sync_g && w_load_ok) bus.in_ready[r_grant] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_rr_last   <= 2'd3;
      r_grant     <= 2'd0;
      r_count     <= '0;
      r_timer     <= '0;
      r_out_byte  <= '0;
      r_out_valid <= 1'b0;
      r_out_sop   <= 1'b0;
      r_out_chan  <= '0;
      r_abort     <= 1'b0;
`ifdef TS_ARB_NULL_INSERT_EN
      r_idle_cnt  <= '0;
`endif
    end else begin
      r_abort <= 1'b0;
      if (bus.out_ready) r_out_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_count <= '0;
          r_timer <= '0;
          if (w_found) begin
            r_grant <= w_pick;
            r_state <= S_XFER;
`ifdef TS_ARB_NULL_INSERT_EN
            r_idle_cnt <= '0;
          end else if (r_idle_cnt == 16'(NULL_WAIT - 1)) begin
            r_idle_cnt <= '0;
            r_state    <= S_NULL;
          end else begin
            r_idle_cnt <= r_idle_cnt + 16'd1;
`endif
          end
        end
        S_XFER: begin
          if (!w_sync_g || w_timeout) begin
            r_abort   <= 1'b1;
            r_rr_last <= r_grant;
            r_state   <= S_IDLE;
          end else if (w_xfer) begin
            r_out_byte  <= w_gbyte;
            r_out_valid <= 1'b1;
            r_out_sop   <= (r_count == 8'd0);
            r_out_chan  <= r_grant;
            r_count     <= r_count + 8'd1;
            r_timer     <= '0;
            if (w_last) begin
              r_rr_last <= r_grant;
              r_state   <= S_IDLE;
            end
          end else begin
            r_timer <= r_timer + 16'd1;
          end
        end
`ifdef TS_ARB_NULL_INSERT_EN
        S_NULL: begin
          if (w_load_ok) begin
            r_out_byte  <= null_byte(r_count);
            r_out_valid <= 1'b1;
            r_out_sop   <= (r_count == 8'd0);
            r_out_chan  <= 2'd0;
            r_count     <= r_count + 8'd1;
            if (w_last) r_state <= S_IDLE;
          end
        end
`endif
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.out_byte  = r_out_byte;
  assign bus.out_valid = r_out_valid;
  assign bus.out_sop   = r_out_sop;
  assign bus.out_chan  = r_out_chan;
  assign bus.abort     = r_abort;

endmodule

// File: tb/tb_ts_packet_arbiter.sv
// Bench for ts_packet_arbiter: randomized per-channel packet sources, an output
// monitor, and a packet-level reference (round-robin order, byte content, timing).
`timescale 1ns/1ps
module tb_ts_packet_arbiter;
  localparam int PKT_LEN = 188, TIMEOUT = 1024, NULL_WAIT = 376;

  logic clk = 1'b0;
  logic rst = 1'b0;
  ts_packet_arbiter_if bus ();
  ts_packet_arbiter #(.PKT_LEN(PKT_LEN), .TIMEOUT(TIMEOUT), .NULL_WAIT(NULL_WAIT))
    dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int cyc;
  logic [7:0] pkt [4][PKT_LEN];
  int  ptr [4], npk [4], stall_at [4], acc_per [4];
  bit  en [4], sy [4];
  int  drop_pct, rdy_pct;
  bit  bp_toggle;
  logic [7:0] exp_q [4][$];
  typedef struct packed {logic [7:0] b; logic sop; logic [1:0] ch;} orec_t;
  orec_t oq [$];
  int  oq_per [$];
  logic [3:0] s_rdy, rdy_at_abort;
  logic s_abort;
  int  n_abort, abort_per, first_acc, stab_bad, n_valid_seen;
  bit  hold_prev;
  logic [7:0] prev_b;
  int  pk_ch [$], pk_len [$], pk_bad [$];

  task automatic new_pkt(input int c);
    logic [7:0] b;
    pkt[c][0] = 8'h47;
    exp_q[c].push_back(8'h47);
    for (int i = 1; i < PKT_LEN; i++) begin
      b = 8'($urandom);
      if (b == 8'h47) b = 8'h46;
      pkt[c][i] = b;
      exp_q[c].push_back(b);
    end
  endtask

  task automatic drive();
    for (int c = 0; c < 4; c++) begin
      bus.in_byte[8*c +: 8] = pkt[c][ptr[c]];
      bus.in_valid[c] = en[c] && (ptr[c] == 0 || $urandom_range(99) >= drop_pct);
      bus.in_sync[c]  = sy[c];
    end
  endtask

  task automatic init_model();
    for (int c = 0; c < 4; c++) begin
      en[c] = 0; sy[c] = 0; ptr[c] = 0; npk[c] = 0; stall_at[c] = -1; acc_per[c] = -1;
      exp_q[c].delete();
      for (int i = 0; i < PKT_LEN; i++) pkt[c][i] = 8'h00;
    end
    drop_pct = 0; rdy_pct = 100; bp_toggle = 0;
    bus.out_ready = 1'b1;
    oq.delete(); oq_per.delete();
    n_abort = 0; abort_per = -1; first_acc = -1; stab_bad = 0; n_valid_seen = 0;
    hold_prev = 0; rdy_at_abort = '0; cyc = 0;
    drive();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    init_model();
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    cyc = 0;
  endtask

  // One clock period: observe at the falling edge, then advance the sources.
  task automatic cycle();
    bit acc [4];
    @(negedge clk);
    s_rdy = bus.in_ready;
    s_abort = bus.abort;
    if (bus.abort) begin n_abort++; abort_per = cyc; rdy_at_abort = bus.in_ready; end
    if (bus.out_valid) n_valid_seen++;
    if (hold_prev && (!bus.out_valid || bus.out_byte !== prev_b)) stab_bad++;
    hold_prev = bus.out_valid && !bus.out_ready;
    prev_b = bus.out_byte;
    if (bus.out_valid && bus.out_ready) begin
      oq.push_back(orec_t'{b: bus.out_byte, sop: bus.out_sop, ch: bus.out_chan});
      oq_per.push_back(cyc);
    end
    for (int c = 0; c < 4; c++) acc[c] = bus.in_ready[c] && bus.in_valid[c];
    @(posedge clk);
    #1;
    for (int c = 0; c < 4; c++) begin
      if (acc[c]) begin
        if (first_acc < 0) first_acc = cyc;
        acc_per[c] = cyc;
        ptr[c]++;
        if (ptr[c] == PKT_LEN) begin
          ptr[c] = 0;
          npk[c]--;
          if (npk[c] > 0) new_pkt(c); else en[c] = 0;
        end else if (ptr[c] == stall_at[c]) en[c] = 0;
      end
    end
    cyc++;
    if (bp_toggle) bus.out_ready = ~bus.out_ready;
    else bus.out_ready = ($urandom_range(99) < rdy_pct);
    drive();
  endtask

  // Cut the output log into packets at each sop; tally bytes that differ from the source.
  function automatic void split_packets();
    int last;
    logic [1:0] ch;
    pk_ch.delete(); pk_len.delete(); pk_bad.delete();
    foreach (oq[i]) begin
      if (oq[i].sop || pk_ch.size() == 0) begin
        pk_ch.push_back(oq[i].sop ? int'(oq[i].ch) : -1);
        pk_len.push_back(0);
        pk_bad.push_back(0);
      end
      last = pk_ch.size() - 1;
      pk_len[last]++;
      ch = oq[i].ch;
      if (int'(ch) != pk_ch[last]) pk_bad[last]++;
      if (exp_q[ch].size() == 0) pk_bad[last]++;
      else if (exp_q[ch].pop_front() !== oq[i].b) pk_bad[last]++;
    end
  endfunction

  task automatic test_reset();
    bit ab_seen;
    init_model();
    npk[0] = 1; new_pkt(0); en[0] = 1; sy[0] = 1; drive();
    #12;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", bus.out_valid); end
    checks++; if (bus.out_byte !== 8'h00) begin errors++; $display("FAIL rst_out_byte got %h want 00", bus.out_byte); end
    checks++; if (bus.out_sop !== 1'b0) begin errors++; $display("FAIL rst_out_sop got %b want 0", bus.out_sop); end
    checks++; if (bus.out_chan !== 2'd0) begin errors++; $display("FAIL rst_out_chan got %0d want 0", bus.out_chan); end
    checks++; if (bus.abort !== 1'b0) begin errors++; $display("FAIL rst_abort got %b want 0", bus.abort); end
    checks++; if (bus.in_ready !== 4'h0) begin errors++; $display("FAIL rst_in_ready got %b want 0000", bus.in_ready); end
    @(posedge clk); #1 rst = 1'b1; cyc = 0;
    repeat (20) cycle();
    checks++; if (oq.size() != 18) begin errors++; $display("FAIL rst_first_bytes got %0d want 18", oq.size()); end
    #3 rst = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 4'h0) begin errors++; $display("FAIL rst_async got valid=%b rdy=%b want 0/0000", bus.out_valid, bus.in_ready); end
    ab_seen = 0;
    repeat (3) begin @(negedge clk); if (bus.abort) ab_seen = 1; end
    @(posedge clk); #1 rst = 1'b1;
    en[0] = 0; drive();
    repeat (5) begin @(negedge clk); if (bus.abort) ab_seen = 1; end
    checks++; if (ab_seen) begin errors++; $display("FAIL rst_no_abort got 1 want 0"); end
  endtask

  task automatic test_single();
    do_reset();
    drop_pct = 15;
    npk[0] = 1; new_pkt(0); en[0] = 1; sy[0] = 1; drive();
    for (int k = 0; k < 1000 && oq.size() < PKT_LEN; k++) cycle();
    repeat (20) cycle();
    checks++; if (first_acc != 1) begin errors++; $display("FAIL single_grant_cycle got %0d want 1", first_acc); end
    checks++; if (oq_per.size() == 0 || oq_per[0] != 2) begin errors++; $display("FAIL single_latency got %0d want 2", oq_per.size() ? oq_per[0] : -1); end
    split_packets();
    checks++; if (pk_ch.size() != 1) begin errors++; $display("FAIL single_pkts got %0d want 1", pk_ch.size()); end
    else begin
      checks++; if (pk_ch[0] != 0 || pk_len[0] != PKT_LEN) begin errors++; $display("FAIL single_shape got ch%0d len%0d want ch0 len%0d", pk_ch[0], pk_len[0], PKT_LEN); end
      checks++; if (pk_bad[0] != 0) begin errors++; $display("FAIL single_bytes got %0d bad want 0", pk_bad[0]); end
    end
    checks++; if (n_abort != 0) begin errors++; $display("FAIL single_abort got %0d want 0", n_abort); end
  endtask

  task automatic test_round_robin();
    int rem [4];
    int rr, total;
    int order [$];
    do_reset();
    rdy_pct = 80; drop_pct = 10;
    npk[0] = 2; npk[1] = 1 + $urandom_range(1); npk[3] = 1 + $urandom_range(1);
    foreach (rem[c]) rem[c] = npk[c];
    for (int c = 0; c < 4; c++) if (npk[c] > 0) begin new_pkt(c); en[c] = 1; sy[c] = 1; end
    drive();
    rr = 3; total = 0;
    while (rem[0] + rem[1] + rem[2] + rem[3] > 0) begin
      for (int s = 1; s <= 4; s++) if (rem[(rr + s) % 4] > 0) begin rr = (rr + s) % 4; break; end
      order.push_back(rr); rem[rr]--; total++;
    end
    for (int k = 0; k < 5000 && oq.size() < total * PKT_LEN; k++) cycle();
    repeat (20) cycle();
    split_packets();
    checks++; if (pk_ch.size() != order.size()) begin errors++; $display("FAIL rr_pkts got %0d want %0d", pk_ch.size(), order.size()); end
    else foreach (order[i]) begin
      checks++; if (pk_ch[i] != order[i] || pk_len[i] != PKT_LEN || pk_bad[i] != 0) begin errors++;
        $display("FAIL rr_pkt%0d got ch%0d len%0d bad%0d want ch%0d len%0d bad0", i, pk_ch[i], pk_len[i], pk_bad[i], order[i], PKT_LEN); end
    end
    checks++; if (n_abort != 0) begin errors++; $display("FAIL rr_abort got %0d want 0", n_abort); end
  endtask

  task automatic test_backpressure();
    do_reset();
    bp_toggle = 1;
    npk[2] = 1; new_pkt(2); en[2] = 1; sy[2] = 1; drive();
    for (int k = 0; k < 1500 && oq.size() < PKT_LEN; k++) cycle();
    repeat (20) cycle();
    split_packets();
    checks++; if (pk_ch.size() != 1) begin errors++; $display("FAIL bp_pkts got %0d want 1", pk_ch.size()); end
    else begin
      checks++; if (pk_ch[0] != 2 || pk_len[0] != PKT_LEN || pk_bad[0] != 0) begin errors++;
        $display("FAIL bp_pkt got ch%0d len%0d bad%0d want ch2 len%0d bad0", pk_ch[0], pk_len[0], pk_bad[0], PKT_LEN); end
    end
    checks++; if (stab_bad != 0) begin errors++; $display("FAIL bp_hold got %0d changes want 0", stab_bad); end
  endtask

  task automatic test_stall_timeout();
    do_reset();
    npk[1] = 1; stall_at[1] = 50; new_pkt(1); en[1] = 1; sy[1] = 1;
    npk[2] = 1; new_pkt(2); en[2] = 1; sy[2] = 1;
    drive();
    for (int k = 0; k < 2000 && n_abort == 0; k++) cycle();
    for (int k = 0; k < 1000 && oq.size() < 50 + PKT_LEN; k++) cycle();
    repeat (20) cycle();
    checks++; if (n_abort != 1) begin errors++; $display("FAIL stall_abort_count got %0d want 1", n_abort); end
    checks++; if (abort_per != acc_per[1] + TIMEOUT + 1) begin errors++; $display("FAIL stall_abort_cycle got %0d want %0d", abort_per, acc_per[1] + TIMEOUT + 1); end
    checks++; if (rdy_at_abort !== 4'h0) begin errors++; $display("FAIL stall_ready got %b want 0000", rdy_at_abort); end
    while (exp_q[1].size() > 50) void'(exp_q[1].pop_back());
    split_packets();
    checks++; if (pk_ch.size() != 2) begin errors++; $display("FAIL stall_pkts got %0d want 2", pk_ch.size()); end
    else begin
      checks++; if (pk_ch[0] != 1 || pk_len[0] != 50 || pk_bad[0] != 0) begin errors++;
        $display("FAIL stall_partial got ch%0d len%0d bad%0d want ch1 len50 bad0", pk_ch[0], pk_len[0], pk_bad[0]); end
      checks++; if (pk_ch[1] != 2 || pk_len[1] != PKT_LEN || pk_bad[1] != 0) begin errors++;
        $display("FAIL stall_next got ch%0d len%0d bad%0d want ch2 len%0d bad0", pk_ch[1], pk_len[1], pk_bad[1], PKT_LEN); end
    end
  endtask

  task automatic test_sync_loss();
    do_reset();
    npk[0] = 1; new_pkt(0); en[0] = 1; sy[0] = 1; drive();
    for (int k = 0; k < 500 && ptr[0] != 100; k++) cycle();
    sy[0] = 0; drive();
    cycle();
    checks++; if (s_rdy[0] !== 1'b0) begin errors++; $display("FAIL sync_ready got %b want 0", s_rdy[0]); end
    cycle();
    checks++; if (s_abort !== 1'b1) begin errors++; $display("FAIL sync_abort got %b want 1", s_abort); end
    repeat (10) cycle();
    sy[0] = 1; drive();
    repeat (10) cycle();
    checks++; if (oq.size() != 100) begin errors++; $display("FAIL sync_no_more got %0d bytes want 100", oq.size()); end
    while (exp_q[0].size() > 100) void'(exp_q[0].pop_back());
    ptr[0] = 0; npk[0] = 1; new_pkt(0); drive();
    for (int k = 0; k < 800 && oq.size() < 100 + PKT_LEN; k++) cycle();
    repeat (10) cycle();
    split_packets();
    checks++; if (pk_ch.size() != 2) begin errors++; $display("FAIL sync_pkts got %0d want 2", pk_ch.size()); end
    else begin
      checks++; if (pk_ch[0] != 0 || pk_len[0] != 100 || pk_bad[0] != 0) begin errors++;
        $display("FAIL sync_partial got ch%0d len%0d bad%0d want ch0 len100 bad0", pk_ch[0], pk_len[0], pk_bad[0]); end
      checks++; if (pk_ch[1] != 0 || pk_len[1] != PKT_LEN || pk_bad[1] != 0) begin errors++;
        $display("FAIL sync_resume got ch%0d len%0d bad%0d want ch0 len%0d bad0", pk_ch[1], pk_len[1], pk_bad[1], PKT_LEN); end
    end
    checks++; if (n_abort != 1) begin errors++; $display("FAIL sync_abort_count got %0d want 1", n_abort); end
  endtask

  task automatic test_null();
    do_reset();
    repeat (700) cycle();
`ifdef TS_ARB_NULL_INSERT_EN
    for (int i = 0; i < PKT_LEN; i++)
      exp_q[0].push_back(i == 0 ? 8'h47 : i == 1 ? 8'h1F : i == 3 ? 8'h10 : 8'hFF);
    split_packets();
    checks++; if (pk_ch.size() != 1) begin errors++; $display("FAIL null_pkts got %0d want 1", pk_ch.size()); end
    else begin
      checks++; if (pk_ch[0] != 0 || pk_len[0] != PKT_LEN || pk_bad[0] != 0) begin errors++;
        $display("FAIL null_pkt got ch%0d len%0d bad%0d want ch0 len%0d bad0", pk_ch[0], pk_len[0], pk_bad[0], PKT_LEN); end
      checks++; if (oq_per[0] < NULL_WAIT || oq_per[0] > NULL_WAIT + 4) begin errors++;
        $display("FAIL null_start got %0d want %0d..%0d", oq_per[0], NULL_WAIT, NULL_WAIT + 4); end
    end
`else
    checks++; if (n_valid_seen != 0) begin errors++; $display("FAIL null_idle got %0d valid cycles want 0", n_valid_seen); end
`endif
    checks++; if (n_abort != 0) begin errors++; $display("FAIL null_abort got %0d want 0", n_abort); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_stall_timeout();
    test_sync_loss();
    test_null();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
